avalon_cmpt_debug_scan_engine: RTL
==================================

# avalon_cmpt_debug_scan_engine

Parametrised scan engine for the Nios II debug slave path of avalon_cmpt. It takes per-TCK strobes and virtual-JTAG state pulses that are already qualified in the `clk` domain. It captures one of `N_CH` status words, shifts it against TDI, and presents each completed update as a held action record under a valid/ready handshake. It replaces the fixed 38-bit, 2-bit-IR debug datapath with configurable data width, IR width and channel count. It adds bit-count checking and overrun reporting, which the fixed path lacks.

## Interface
Parameters:
- `DR_W`, 38, data register width; must be ≥ 2.
- `IR_W`, 2, instruction register width; must be ≥ 2.
- `N_CH`, 4, number of capture channels; must be ≤ 2**IR_W.
- `CNT_W`, $clog2(DR_W+2), bit-counter width (derived; do not override).

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset (already decided).
- `tck_en`  in  1  one-`clk` strobe per TCK rising edge; all `vs_*` and `tdi` are sampled only when this is high.
- `tdi`  in  1  serial data in.
- `vs_cdr`, `vs_sdr`, `vs_udr`, `vs_uir`  in  1 each  virtual capture-DR, shift-DR, update-DR and update-IR states.
- `ir_in`  in  IR_W  instruction value, valid with `vs_uir`.
- `cap_data`  in  N_CH*DR_W  capture words; channel k occupies bits [k*DR_W +: DR_W].
- `act_ready`  in  1  consumer accepts the current action.
- `tdo`  out  1  serial data out, equal to `sr[0]`.
- `ir_out`  out  IR_W  status: bit0 = `act_valid`, bit1 = `overrun`, higher bits 0.
- `jdo`  out  DR_W  shifted data of the held action.
- `act_ir`  out  IR_W  IR value latched with the action.
- `act_short`  out  1  the action's shift count was not exactly DR_W.
- `act_valid`  out  1  an action is held.
- `overrun`  out  1  sticky flag: an update was dropped because an action was still held.

## Operation
- Registers:
  - `ir_q` (IR_W)
  - `sr` (DR_W)
  - `bitcnt` (CNT_W, saturates at DR_W+1)
  - `state` ∈ {S_IDLE, S_SHIFT}
  - the action record (`jdo`, `act_ir`, `act_short`, `act_valid`)
  - `overrun`
- Only events with `tck_en`=1 are processed. Fixed priority when several strobes coincide: uir > cdr > sdr > udr. Exactly one strobe is acted on per cycle.
- **uir:**
  - `ir_q` ← `ir_in`; `overrun` ← 0.
  - `state` ← S_IDLE; any scan in progress is abandoned.
- **cdr (any state):**
  - If `ir_q` < N_CH: `sr` ← channel `ir_q` of `cap_data`. Otherwise `sr` ← 0.
  - `bitcnt` ← 0; `state` ← S_SHIFT.
- **sdr in S_SHIFT:** `sr` ← {`tdi`, `sr[DR_W-1:1]`}; `bitcnt` increments, saturating at DR_W+1. In S_IDLE, sdr is ignored.
- **udr in S_SHIFT:**
  - `state` ← S_IDLE.
  - The record slot is free if `act_valid`=0, or if `act_valid`=1 and `act_ready`=1 in the same cycle.
  - If the slot is free, load it: `jdo` ← `sr`, `act_ir` ← `ir_q`, `act_short` ← (`bitcnt` ≠ DR_W), `act_valid` ← 1.
  - If the slot is not free, the update is dropped and `overrun` ← 1.
- **udr in S_IDLE:** ignored.
- **Handshake:**
  - `act_valid` & `act_ready` with no load in the same cycle → `act_valid` ← 0. `jdo`, `act_ir` and `act_short` keep their values.
  - While `act_valid`=1, `jdo`, `act_ir` and `act_short` are stable.
- A high `act_ready` while `act_valid`=0 has no effect.

## Timing
- Every output is a register or a direct register bit; there are no combinational input-to-output paths.
- Reset values:
  - all outputs 0 (`tdo`, `ir_out`, `jdo`, `act_ir`, `act_short`, `act_valid`, `overrun`)
  - `sr` = 0, `ir_q` = 0, `bitcnt` = 0, `state` = S_IDLE
- Reset wins over every strobe in the same cycle. Reset mid-scan discards the scan and any held action.
- Latency:
  - `tdo` reflects a shift one `clk` after the sdr cycle.
  - `act_valid` and `jdo` are updated one `clk` after the udr cycle.
  - `ir_out` follows `act_valid` and `overrun` in the same cycle they change.
- Throughput: one action per udr. Back-to-back udr with `act_ready` held at 1 loses nothing.

## Structure
- Package `avalon_cmpt_debug_pkg`:
  - state enum `dbg_scan_state_t` {S_IDLE, S_SHIFT}
  - IR code constants: IR_OCIMEM=0, IR_BREAK=1, IR_TRACE=2, IR_MON=3
  - `ir_out` bit indices: ST_PENDING=0, ST_OVERRUN=1
- One sub-module, `avalon_cmpt_debug_action_reg`. It holds the action record with the valid/ready load/drop/overrun logic. The top level keeps `ir_q`, `sr`, `bitcnt` and the FSM.

## Test plan
- **Basic scan:** uir(`ir_in`=1); cdr with ch1=0x2A_AAAA_AAAA; 38 sdr with `tdi`=1; udr.
  - `tdo` sequence = 0,1,0,1,… (LSB first).
  - `jdo` = 0x3F_FFFF_FFFF, `act_ir`=1, `act_short`=0, `act_valid`=1 one cycle after udr.
- **Short and long scans:**
  - 5 sdr then udr → `act_short`=1, `jdo[37:33]` = tdi bits.
  - 45 sdr → `bitcnt` saturates at 39, `act_short`=1.
- **Overrun:**
  - Two udr with `act_ready`=0 → second is dropped, `overrun`=1, `ir_out`=2'b11, `jdo` unchanged.
  - A following uir clears `overrun`.
- **Simultaneous load/accept:** `act_valid`=1, udr in the same cycle as `act_ready`=1 → new record loaded, `act_valid` stays 1, `overrun`=0.
- **Priority and gating:**
  - uir+cdr in one `tck_en` cycle → only `ir_q` is updated, state S_IDLE.
  - A strobe with `tck_en`=0 causes no change.
  - `ir_q`=3 with N_CH=3 → cdr captures 0.
- **Reset mid-scan:** `reset`=1 after 10 sdr → all outputs 0, state S_IDLE; a subsequent udr without cdr → no action.

Source files
------------

// File: rtl/avalon_cmpt_debug_pkg.sv
// avalon_cmpt_debug_pkg
// Shared types and constants for the avalon_cmpt debug scan engine:
//   - dbg_scan_state_t : scan FSM state (idle / shifting)
//   - IR_* codes       : instruction register values of the debug slave
//   - ST_* indices     : bit positions of the status word driven on ir_out
package avalon_cmpt_debug_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } dbg_scan_state_t;

    localparam int IR_OCIMEM = 0;
    localparam int IR_BREAK  = 1;
    localparam int IR_TRACE  = 2;
    localparam int IR_MON    = 3;

    localparam int ST_PENDING = 0;
    localparam int ST_OVERRUN = 1;

endpackage

// File: rtl/avalon_cmpt_debug_action_reg.sv
// avalon_cmpt_debug_action_reg
// Holds one completed scan as an action record under a valid/ready handshake
// and keeps the sticky overrun flag.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   load_req         : an update-DR that ended a scan this cycle
//   clear_overrun    : update-IR this cycle, clears the sticky flag
//   load_data/ir/short : record contents offered with load_req
//   act_ready        : consumer accepts the held record
//   jdo, act_ir, act_short, act_valid : held record
//   overrun          : an update was dropped while a record was still held
module avalon_cmpt_debug_action_reg #(
    parameter int DR_W = 38,
    parameter int IR_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_req,
    input  logic            clear_overrun,
    input  logic [DR_W-1:0] load_data,
    input  logic [IR_W-1:0] load_ir,
    input  logic            load_short,
    input  logic            act_ready,
    output logic [DR_W-1:0] jdo,
    output logic [IR_W-1:0] act_ir,
    output logic            act_short,
    output logic            act_valid,
    output logic            overrun
);

    // The slot can take a new record when empty, or when the consumer is
    // taking the current one in this very cycle.
    logic slot_free;
    assign slot_free = ~act_valid | act_ready;

    // Record fields only change on a load, so they stay stable while valid
    // and keep their last value after the consumer takes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            jdo       <= '0;
            act_ir    <= '0;
            act_short <= 1'b0;
            act_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load_req && slot_free) begin
                jdo       <= load_data;
                act_ir    <= load_ir;
                act_short <= load_short;
                act_valid <= 1'b1;
            end else if (act_valid && act_ready) begin
                act_valid <= 1'b0;
            end

            if (clear_overrun) begin
                overrun <= 1'b0;
            end else if (load_req && !slot_free) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/avalon_cmpt_debug_scan_engine.sv
// avalon_cmpt_debug_scan_engine
// Scan engine for the Nios II debug slave path. Captures one of N_CH status
// words on capture-DR, shifts it against TDI (LSB out first on tdo) and hands
// each completed update-DR to the action register.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   tck_en            : one-clk strobe per TCK rising edge, qualifies all below
//   tdi               : serial data in
//   vs_cdr/sdr/udr/uir: virtual JTAG state pulses
//   ir_in             : instruction value, valid with vs_uir
//   cap_data          : N_CH capture words, channel k at [k*DR_W +: DR_W]
//   act_ready         : consumer accepts the held action
//   tdo               : sr[0]
//   ir_out            : status {.., overrun, act_valid}
//   jdo, act_ir, act_short, act_valid, overrun : held action and sticky flag
module avalon_cmpt_debug_scan_engine
    import avalon_cmpt_debug_pkg::*;
#(
    parameter int DR_W  = 38,
    parameter int IR_W  = 2,
    parameter int N_CH  = 4,
    parameter int CNT_W = $clog2(DR_W + 2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tck_en,
    input  logic                 tdi,
    input  logic                 vs_cdr,
    input  logic                 vs_sdr,
    input  logic                 vs_udr,
    input  logic                 vs_uir,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [N_CH*DR_W-1:0] cap_data,
    input  logic                 act_ready,
    output logic                 tdo,
    output logic [IR_W-1:0]      ir_out,
    output logic [DR_W-1:0]      jdo,
    output logic [IR_W-1:0]      act_ir,
    output logic                 act_short,
    output logic                 act_valid,
    output logic                 overrun
);

    logic [IR_W-1:0]  ir_q;
    logic [DR_W-1:0]  sr;
    logic [CNT_W-1:0] bitcnt;
    dbg_scan_state_t  state;

    // Only one strobe acts per cycle: uir beats cdr beats sdr beats udr.
    logic do_uir, do_cdr, do_sdr, do_udr;
    assign do_uir = tck_en & vs_uir;
    assign do_cdr = tck_en & vs_cdr & ~vs_uir;
    assign do_sdr = tck_en & vs_sdr & ~vs_uir & ~vs_cdr;
    assign do_udr = tck_en & vs_udr & ~vs_uir & ~vs_cdr & ~vs_sdr;

    logic load_req;
    assign load_req = do_udr && (state == S_SHIFT);

    // Instruction codes beyond the last channel capture all zeros.
    logic [DR_W-1:0] cap_word;
    always_comb begin
        cap_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ir_q == IR_W'(k)) begin
                cap_word = cap_data[k*DR_W +: DR_W];
            end
        end
    end

    // Scan FSM with shift register and saturating bit counter. The counter
    // stops at DR_W+1 so any over-long scan still reads as "not DR_W".
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q   <= '0;
            sr     <= '0;
            bitcnt <= '0;
            state  <= S_IDLE;
        end else if (do_uir) begin
            ir_q  <= ir_in;
            state <= S_IDLE;
        end else if (do_cdr) begin
            sr     <= cap_word;
            bitcnt <= '0;
            state  <= S_SHIFT;
        end else if (do_sdr && state == S_SHIFT) begin
            sr <= {tdi, sr[DR_W-1:1]};
            if (bitcnt != CNT_W'(DR_W + 1)) begin
                bitcnt <= bitcnt + 1'b1;
            end
        end else if (load_req) begin
            state <= S_IDLE;
        end
    end

    avalon_cmpt_debug_action_reg #(
        .DR_W (DR_W),
        .IR_W (IR_W)
    ) u_action (
        .clk           (clk),
        .reset         (reset),
        .load_req      (load_req),
        .clear_overrun (do_uir),
        .load_data     (sr),
        .load_ir       (ir_q),
        .load_short    (bitcnt != CNT_W'(DR_W)),
        .act_ready     (act_ready),
        .jdo           (jdo),
        .act_ir        (act_ir),
        .act_short     (act_short),
        .act_valid     (act_valid),
        .overrun       (overrun)
    );

    assign tdo = sr[0];

    always_comb begin
        ir_out             = '0;
        ir_out[ST_PENDING] = act_valid;
        ir_out[ST_OVERRUN] = overrun;
    end

endmodule
